uart_rx_fsm: RTL and testbench
==============================

# uart_rx_fsm

Oversampling UART receiver and the counterpart to the team's UART transmitter. It sits between the asynchronous serial input pin and the byte-level consumer. The line is sampled at 16x baud, a start bit is qualified at mid-bit, and data bits are sampled at bit centres, LSB first. Each received frame is presented as a parallel byte with a one-cycle valid strobe plus parity and framing error flags.

## Interface
- OVERSAMPLE, 16: sample ticks per bit; must be an even value ≥ 4.
- DATA_BITS, 8: data bits per frame, 5..8.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate; all FSM and counter activity advances only on cycles where tick=1.
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  last received byte, held until the next frame completes.
- rx_valid  output  1  one-clk pulse when rx_data/parity_err/frame_err update.
- parity_err  output  1  parity mismatch for the frame in rx_data.
- frame_err  output  1  stop bit sampled low for the frame in rx_data.
- busy  output  1  high in any state other than IDLE.

Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.

## Operation
- rx passes through a 2-flop synchronizer (rx_s). Synchronizer flops reset to 1.
- States are IDLE, START, DATA, PARITY, STOP. The tick counter is tcnt, log2(OVERSAMPLE) bits. The bit counter is bcnt, 3 bits. There is a DATA_BITS-wide shift register.
- IDLE: the armed flag sets when rx_s=1 on a tick. When armed and rx_s=0 on a tick, the FSM goes to START, clears tcnt and clears armed.
- START: tcnt increments per tick. At tcnt=OVERSAMPLE/2-1, the FSM checks rx_s:
  - rx_s=1 is a false start. The FSM returns to IDLE with no output.
  - rx_s=0 clears tcnt and bcnt, and the FSM goes to DATA.
- DATA: at tcnt=OVERSAMPLE-1 (bit centre), the FSM shifts rx_s into the MSB (right shift, so LSB first), clears tcnt, and increments bcnt. After the DATA_BITS-th sample it goes to PARITY (or STOP when parity is compiled out).
- PARITY: the bit is sampled at the centre. The computed error is latched internally and is not visible until the frame commits.
- STOP: the bit is sampled at the centre, and the frame commits in the same clk:
  - rx_data <= shift register
  - frame_err <= ~rx_s
  - parity_err <= latched value
  - rx_valid=1
  - the FSM goes to IDLE
- Frames with errors still pulse rx_valid; the flags qualify the data.
- After a frame error, armed is clear. A break (rx held low) therefore produces exactly one frame and no further frames until rx returns high.
- Reset mid-frame: the FSM returns to IDLE on the next clk. The partial frame is discarded and no rx_valid is produced.
- The default/illegal state encoding goes to IDLE.

## Timing
- Reset values:
  - rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0
  - state=IDLE, armed=0, tcnt=0, bcnt=0
- Input latency: 2 clk through the synchronizer.
- Frame latency from the first tick with rx_s=0 to the rx_valid clk: OVERSAMPLE/2 + OVERSAMPLE x (DATA_BITS+2) ticks, which is 168 ticks at the defaults. Without parity it is one bit time less (152 ticks).
- rx_valid is registered. It is high for exactly one clk, and that clk does not need tick=1 after the commit tick.
- busy rises the clk after start detection and falls in the same clk as rx_valid.
- A new start bit can be accepted on the tick after the return to IDLE if armed. A valid stop bit sets armed, because rx_s=1 at the stop-bit centre.
- Tolerated baud mismatch is about ±4% at the defaults, from centre sampling.

## Configuration
- UART_RX_PARITY_EN defined: a PARITY state exists after DATA. Parity is even: parity_err = XOR(data bits, parity bit).
- UART_RX_PARITY_EN undefined:
  - the PARITY state, its logic and the latch are removed
  - DATA goes directly to STOP
  - parity_err is tied to 0
  - the frame is DATA_BITS+2 bits

## Test plan
- Reset, then frame 0xA5 with parity 0 and stop 1 at OVERSAMPLE=16 (parity on) -> rx_valid pulse once 168 ticks after the start edge; rx_data=0xA5, parity_err=0, frame_err=0.
- Frame 0x3C with parity bit 1 (wrong) -> rx_data=0x3C, parity_err=1, frame_err=0; next good frame 0x01 clears parity_err.
- Frame 0xFF with stop bit 0, then rx held low for 40 bit times -> exactly one rx_valid with frame_err=1; no further rx_valid until rx goes high and a new start arrives.
- rx low glitch for 5 ticks in IDLE -> busy pulses, no rx_valid, and the FSM is back in IDLE.
- rst asserted for one clk at bcnt=4 of a frame, then a full frame 0x5A -> only one rx_valid, with rx_data=0x5A.
- Build without UART_RX_PARITY_EN and send back-to-back frames 0x00, 0x80 with no idle gap -> two rx_valid pulses 160 ticks apart, data correct, parity_err=0 always.

Source files
------------

// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if: serial input, sample tick and received-byte bus of the
// oversampling UART receiver. The receiver uses the slave modport; the
// block driving the line and consuming bytes uses the master modport.
interface uart_rx_fsm_if #(
    parameter int DATA_BITS = 8
);
    logic                 tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport slave (
        input  tick, rx,
        output rx_data, rx_valid, parity_err, frame_err, busy
    );

    modport master (
        output tick, rx,
        input  rx_data, rx_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: 16x oversampling UART receiver. Start bit is qualified at
// mid-bit, data bits are sampled at bit centres LSB first, and each frame
// commits as a byte with a one-clk valid strobe plus parity/framing flags.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after data).
module uart_rx_fsm #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic         clk,
    input  logic         rst,
    uart_rx_fsm_if.slave bus
);
    localparam int             TW       = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  HALF_M1  = TW'(OVERSAMPLE/2 - 1);
    localparam logic [TW-1:0]  FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0]  TCNT_ONE = TW'(1);
    localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic                 r_rx_meta, r_rx_s;
    state_t               r_state, w_state_nxt;
    logic                 r_armed, w_armed_nxt;
    logic [TW-1:0]        r_tcnt, w_tcnt_nxt;
    logic [2:0]           r_bcnt, w_bcnt_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [DATA_BITS-1:0] r_data, w_data_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_ferr, w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic                 r_par, w_par_nxt;     // parity error of frame in flight
    logic                 r_perr, w_perr_nxt;
`endif

    // Two-flop synchronizer on the asynchronous line; idles high out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
            r_tcnt  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_armed <= w_armed_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par_nxt;
            r_perr  <= w_perr_nxt;
`endif
        end
    end

    // Next-state and datapath updates; everything holds except on tick,
    // and the valid strobe drops on the following clk regardless of tick
    always_comb begin
        w_state_nxt = r_state;
        w_armed_nxt = r_armed;
        w_tcnt_nxt  = r_tcnt;
        w_bcnt_nxt  = r_bcnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = r_ferr;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par;
        w_perr_nxt  = r_perr;
`endif
        if (bus.tick) begin
            case (r_state)
                S_IDLE: begin
                    // armed guards against a line that is already low (break)
                    if (r_rx_s) begin
                        w_armed_nxt = 1'b1;
                    end else if (r_armed) begin
                        w_state_nxt = S_START;
                        w_tcnt_nxt  = '0;
                        w_armed_nxt = 1'b0;
                    end
                end
                S_START: begin
                    if (r_tcnt == HALF_M1) begin
                        w_tcnt_nxt = '0;
                        if (r_rx_s) begin
                            w_state_nxt = S_IDLE;   // glitch, not a start bit
                        end else begin
                            w_bcnt_nxt  = '0;
                            w_state_nxt = S_DATA;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + TCNT_ONE;
                    end
                end
                S_DATA: begin
                    if (r_tcnt == FULL_M1) begin
                        w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
                        w_tcnt_nxt  = '0;
                        w_bcnt_nxt  = r_bcnt + 3'd1;
                        if (r_bcnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = S_PARITY;
`else
                            w_state_nxt = S_STOP;
`endif
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + TCNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_tcnt == FULL_M1) begin
                        // even parity: data plus parity bit must XOR to 0
                        w_par_nxt   = ^{r_shift, r_rx_s};
                        w_tcnt_nxt  = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_tcnt_nxt = r_tcnt + TCNT_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (r_tcnt == FULL_M1) begin
                        w_data_nxt  = r_shift;
                        w_ferr_nxt  = ~r_rx_s;
`ifdef UART_RX_PARITY_EN
                        w_perr_nxt  = r_par;
`endif
                        w_valid_nxt = 1'b1;
                        // good stop bit re-arms so a back-to-back start is taken
                        w_armed_nxt = r_rx_s;
                        w_tcnt_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_tcnt_nxt = r_tcnt + TCNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_armed_nxt = 1'b0;
                    w_tcnt_nxt  = '0;
                    w_bcnt_nxt  = '0;
                end
            endcase
        end
    end

    assign bus.rx_data  = r_data;
    assign bus.rx_valid = r_valid;
    assign bus.frame_err = r_ferr;
    assign bus.busy     = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = r_perr;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed bench for uart_rx_fsm at OVERSAMPLE=16,
// DATA_BITS=8. Tick runs every other clk; each serial bit is held for
// OVERSAMPLE ticks. Adapts frame format to UART_RX_PARITY_EN.
module tb_uart_rx_fsm;
    localparam int OS = 16;
    localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LAT     = OS/2 + OS*(DB + 1 + PAR);  // 168 with parity, 152 without
    localparam int FRAME_T = OS*(DB + 2 + PAR);         // 176 with parity, 160 without
    localparam int BIT_CLK = 2*OS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_ph = 1'b0;
    int   checks = 0;
    int   errs = 0;

    uart_rx_fsm_if #(.DATA_BITS(DB)) bus();

    uart_rx_fsm #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(negedge clk) tick_ph <= ~tick_ph;
    assign bus.tick = tick_ph;

    int tcount = 0;
    always @(posedge clk) if (bus.tick) tcount <= tcount + 1;

    // observation of strobes, captured away from the active edge
    int          vcnt = 0, nbusy = 0, perr_cnt = 0, wide = 0;
    int          t_busy = 0, t_last = 0, t_prev = 0;
    logic [7:0]  d_last = 8'h00, d_prev = 8'h00;
    logic        p_last = 1'b0, f_last = 1'b0, vld_q = 1'b0, busy_q = 1'b0;
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            vcnt   <= vcnt + 1;
            t_prev <= t_last;
            t_last <= tcount;
            d_prev <= d_last;
            d_last <= bus.rx_data;
            p_last <= bus.parity_err;
            f_last <= bus.frame_err;
            if (bus.parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
            if (vld_q) wide <= wide + 1;
        end
        if (bus.busy === 1'b1 && !busy_q) begin
            t_busy <= tcount;
            nbusy  <= nbusy + 1;
        end
        vld_q  <= (bus.rx_valid === 1'b1);
        busy_q <= (bus.busy === 1'b1);
    end

    task automatic send_bit(input logic b);
        bus.rx = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        if (PAR == 1) send_bit(p);
        send_bit(stop);
    endtask

    task automatic test_reset();
        bus.rx = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.rx_data !== 8'h00)    begin errs++; $display("FAIL reset_data: got %h want 00", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0)    begin errs++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
        checks++; if (bus.parity_err !== 1'b0)  begin errs++; $display("FAIL reset_perr: got %b want 0", bus.parity_err); end
        checks++; if (bus.frame_err !== 1'b0)   begin errs++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err); end
        checks++; if (bus.busy !== 1'b0)        begin errs++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        repeat (2) send_bit(1'b1);
    endtask

    task automatic test_basic();
        int v0;
        v0 = vcnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        send_bit(1'b1);
        checks++; if (vcnt - v0 !== 1)     begin errs++; $display("FAIL basic_count: got %0d want 1", vcnt - v0); end
        checks++; if (d_last !== 8'hA5)    begin errs++; $display("FAIL basic_data: got %h want a5", d_last); end
        checks++; if (p_last !== 1'b0)     begin errs++; $display("FAIL basic_perr: got %b want 0", p_last); end
        checks++; if (f_last !== 1'b0)     begin errs++; $display("FAIL basic_ferr: got %b want 0", f_last); end
        checks++; if (t_last - t_busy !== LAT) begin errs++; $display("FAIL basic_latency: got %0d want %0d", t_last - t_busy, LAT); end
        checks++; if (wide !== 0)          begin errs++; $display("FAIL valid_width: got %0d wide pulses want 0", wide); end
        checks++; if (bus.busy !== 1'b0)   begin errs++; $display("FAIL basic_idle: busy %b want 0", bus.busy); end
    endtask

    task automatic test_parity();
        send_frame(8'h3C, 1'b1, 1'b1);
        send_bit(1'b1);
        checks++; if (d_last !== 8'h3C)    begin errs++; $display("FAIL par_bad_data: got %h want 3c", d_last); end
        checks++; if (p_last !== PAR[0])   begin errs++; $display("FAIL par_bad_perr: got %b want %b", p_last, PAR[0]); end
        checks++; if (f_last !== 1'b0)     begin errs++; $display("FAIL par_bad_ferr: got %b want 0", f_last); end
        send_frame(8'h01, 1'b1, 1'b1);
        send_bit(1'b1);
        checks++; if (d_last !== 8'h01)    begin errs++; $display("FAIL par_good_data: got %h want 01", d_last); end
        checks++; if (p_last !== 1'b0)     begin errs++; $display("FAIL par_good_perr: got %b want 0", p_last); end
    endtask

    task automatic test_glitch();
        int v0, b0;
        v0 = vcnt; b0 = nbusy;
        bus.rx = 1'b0;
        repeat (10) @(negedge clk);   // 5 ticks low
        bus.rx = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (nbusy - b0 !== 1)   begin errs++; $display("FAIL glitch_busy_pulse: got %0d want 1", nbusy - b0); end
        checks++; if (vcnt !== v0)        begin errs++; $display("FAIL glitch_valid: got %0d pulses want 0", vcnt - v0); end
        checks++; if (bus.busy !== 1'b0)  begin errs++; $display("FAIL glitch_idle: busy %b want 0", bus.busy); end
    endtask

    task automatic test_break();
        int v0;
        v0 = vcnt;
        send_frame(8'hFF, 1'b0, 1'b0);
        bus.rx = 1'b0;
        repeat (40*BIT_CLK) @(negedge clk);
        checks++; if (vcnt - v0 !== 1)    begin errs++; $display("FAIL break_count: got %0d want 1", vcnt - v0); end
        checks++; if (d_last !== 8'hFF)   begin errs++; $display("FAIL break_data: got %h want ff", d_last); end
        checks++; if (f_last !== 1'b1)    begin errs++; $display("FAIL break_ferr: got %b want 1", f_last); end
        checks++; if (bus.busy !== 1'b0)  begin errs++; $display("FAIL break_idle: busy %b want 0", bus.busy); end
        repeat (2) send_bit(1'b1);
        send_frame(8'h81, 1'b0, 1'b1);
        send_bit(1'b1);
        checks++; if (vcnt - v0 !== 2)    begin errs++; $display("FAIL break_recover_count: got %0d want 2", vcnt - v0); end
        checks++; if (d_last !== 8'h81 || f_last !== 1'b0) begin errs++; $display("FAIL break_recover: got %h/%b want 81/0", d_last, f_last); end
    endtask

    task automatic test_reset_mid();
        int v0;
        logic [7:0] d;
        d = 8'h5A;
        v0 = vcnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        bus.rx = d[4];
        repeat (OS) @(negedge clk);   // half-way into bit 4
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0)  begin errs++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        bus.rx = 1'b1;
        repeat (3) send_bit(1'b1);
        send_frame(d, 1'b0, 1'b1);
        send_bit(1'b1);
        checks++; if (vcnt - v0 !== 1)    begin errs++; $display("FAIL rstmid_count: got %0d want 1", vcnt - v0); end
        checks++; if (d_last !== 8'h5A)   begin errs++; $display("FAIL rstmid_data: got %h want 5a", d_last); end
    endtask

    task automatic test_back_to_back();
        int v0, pe0;
        v0 = vcnt; pe0 = perr_cnt;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'h80, 1'b1, 1'b1);
        send_bit(1'b1);
        checks++; if (vcnt - v0 !== 2)    begin errs++; $display("FAIL b2b_count: got %0d want 2", vcnt - v0); end
        checks++; if (d_prev !== 8'h00)   begin errs++; $display("FAIL b2b_data0: got %h want 00", d_prev); end
        checks++; if (d_last !== 8'h80)   begin errs++; $display("FAIL b2b_data1: got %h want 80", d_last); end
        checks++; if (t_last - t_prev !== FRAME_T) begin errs++; $display("FAIL b2b_spacing: got %0d want %0d", t_last - t_prev, FRAME_T); end
        checks++; if (perr_cnt !== pe0)   begin errs++; $display("FAIL b2b_perr: got %0d flagged want 0", perr_cnt - pe0); end
        checks++; if (wide !== 0)         begin errs++; $display("FAIL b2b_width: got %0d wide pulses want 0", wide); end
    endtask

    initial begin
        bus.rx = 1'b1;
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_break();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
